// File: rtl/packet_parse.sv
// Receive-side parser for the generator's 32-bit word stream: rebuilds the packet
// metadata word, checks framing, and reports per-packet errors and counts.
module packet_parse #(
    parameter int unsigned PORT_CNT  = 4,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic                 in_sop,
    input  logic [31:0]          in_data,
    output logic                 meta_valid,
    output logic [31:0]          meta_out,
    output logic [3:0]           err,
    output logic [CNT_WIDTH-1:0] pkt_cnt,
    output logic [CNT_WIDTH-1:0] err_cnt
);

    typedef enum logic [2:0] {
        IDLE, DMAC_SND, TIME_FST, TIME_SND, SMAC_FST, SMAC_SND, PAYLOAD
    } state_t;

    function automatic logic [47:0] port_to_mac(input int unsigned p);
        return 48'h02AB_CD00_0000 + 48'(p);
    endfunction

    // Returns {hit, port}; one comparator per port.
    function automatic logic [2:0] mac_lookup(input logic [47:0] mac);
        logic [2:0] r;
        r = '0;
        for (int unsigned p = 0; p < PORT_CNT; p++) begin
            if (mac == port_to_mac(p)) r = {1'b1, p[1:0]};
        end
        return r;
    endfunction

    state_t                 state_q, state_d;
    logic [5:0]             len_q, len_d;
    logic [15:0]            mac_hi_q, mac_hi_d;
    logic [1:0]             dst_q, dst_d;
    logic [1:0]             src_q, src_d;
    logic [21:0]            time_q, time_d;
    logic [5:0]             rem_q, rem_d;
    logic                   pay_e_q, pay_e_d;
    logic                   fmt_e_q, fmt_e_d;
    logic                   mac_e_q, mac_e_d;
    logic                   meta_valid_q, meta_valid_d;
    logic [31:0]            meta_q, meta_d;
    logic [3:0]             err_q, err_d;
    logic [CNT_WIDTH-1:0]   pkt_cnt_q, pkt_cnt_d;
    logic [CNT_WIDTH-1:0]   err_cnt_q, err_cnt_d;
    logic [1:0]             rsync_q;
    logic                   acc;
    logic [2:0]             lookup;
    logic                   pay_now;

    // Reset asserts asynchronously but parsing only resumes once release is synchronised.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rsync_q <= '0;
        else        rsync_q <= {rsync_q[0], 1'b1};
    end

    assign acc     = in_valid & rsync_q[1];
    assign lookup  = mac_lookup({mac_hi_q, in_data});
    assign pay_now = pay_e_q | (in_data != '1);

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        mac_hi_d     = mac_hi_q;
        dst_d        = dst_q;
        src_d        = src_q;
        time_d       = time_q;
        rem_d        = rem_q;
        pay_e_d      = pay_e_q;
        fmt_e_d      = fmt_e_q;
        mac_e_d      = mac_e_q;
        meta_valid_d = 1'b0;
        meta_d       = meta_q;
        err_d        = err_q;
        pkt_cnt_d    = pkt_cnt_q;
        err_cnt_d    = err_cnt_q;

        if (acc) begin
            if (in_sop) begin
                // A sop outside IDLE closes the open packet as truncated, then starts afresh.
                if (state_q != IDLE) begin
                    meta_valid_d = 1'b1;
                    meta_d       = {src_q, dst_q, len_q, time_q};
                    err_d        = {pay_e_q, fmt_e_q, mac_e_q, 1'b1};
                    err_cnt_d    = err_cnt_q + CNT_WIDTH'(1);
                end
                len_d    = in_data[26:21];
                mac_hi_d = in_data[15:0];
                pay_e_d  = 1'b0;
                mac_e_d  = 1'b0;
                fmt_e_d  = (in_data[31:27] != '0) || (in_data[20:16] != '0);
                state_d  = DMAC_SND;
            end else begin
                unique case (state_q)
                    IDLE: ;
                    DMAC_SND: begin
                        dst_d   = lookup[2] ? lookup[1:0] : 2'd0;
                        mac_e_d = mac_e_q | ~lookup[2];
                        state_d = TIME_FST;
                    end
                    TIME_FST: begin
                        time_d  = in_data[21:0];
                        fmt_e_d = fmt_e_q | (in_data[31:22] != '0);
                        state_d = TIME_SND;
                    end
                    TIME_SND: begin
                        fmt_e_d = fmt_e_q | (in_data != '0);
                        state_d = SMAC_FST;
                    end
                    SMAC_FST: begin
                        fmt_e_d  = fmt_e_q | (in_data[31:16] != '0);
                        mac_hi_d = in_data[15:0];
                        state_d  = SMAC_SND;
                    end
                    SMAC_SND: begin
                        src_d   = lookup[2] ? lookup[1:0] : 2'd0;
                        mac_e_d = mac_e_q | ~lookup[2];
                        rem_d   = len_q;
                        state_d = PAYLOAD;
                    end
                    PAYLOAD: begin
                        pay_e_d = pay_now;
                        if (rem_q != '0) begin
                            rem_d = rem_q - 6'd1;
                        end else begin
                            meta_valid_d = 1'b1;
                            meta_d       = {src_q, dst_q, len_q, time_q};
                            err_d        = {pay_now, fmt_e_q, mac_e_q, 1'b0};
                            pkt_cnt_d    = pkt_cnt_q + CNT_WIDTH'(1);
                            if (pay_now || fmt_e_q || mac_e_q)
                                err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
                            state_d      = IDLE;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            len_q        <= '0;
            mac_hi_q     <= '0;
            dst_q        <= '0;
            src_q        <= '0;
            time_q       <= '0;
            rem_q        <= '0;
            pay_e_q      <= 1'b0;
            fmt_e_q      <= 1'b0;
            mac_e_q      <= 1'b0;
            meta_valid_q <= 1'b0;
            meta_q       <= '0;
            err_q        <= '0;
            pkt_cnt_q    <= '0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            mac_hi_q     <= mac_hi_d;
            dst_q        <= dst_d;
            src_q        <= src_d;
            time_q       <= time_d;
            rem_q        <= rem_d;
            pay_e_q      <= pay_e_d;
            fmt_e_q      <= fmt_e_d;
            mac_e_q      <= mac_e_d;
            meta_valid_q <= meta_valid_d;
            meta_q       <= meta_d;
            err_q        <= err_d;
            pkt_cnt_q    <= pkt_cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign meta_valid = meta_valid_q;
    assign meta_out   = meta_q;
    assign err        = err_q;
    assign pkt_cnt    = pkt_cnt_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_packet_parse.sv
// Bench for packet_parse: fixed vector table, hand-built abort/reset sequences and
// random packets, all scored against intent-level expectations.
module tb_packet_parse;

    localparam logic [15:0] MAC_HI = 16'h02AB;
    localparam logic [31:0] MAC_LO = 32'hCD00_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_sop = 1'b0;
    logic [31:0] in_data = '0;
    logic        meta_valid;
    logic [31:0] meta_out;
    logic [3:0]  err;
    logic [15:0] pkt_cnt;
    logic [15:0] err_cnt;

    packet_parse #(.PORT_CNT(4), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_sop(in_sop),
        .in_data(in_data), .meta_valid(meta_valid), .meta_out(meta_out),
        .err(err), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] meta;
        logic [3:0]  err;
        bit          chk_meta;
        logic [15:0] pc;
        logic [15:0] ec;
        int          neg;
    } exp_t;

    typedef struct {
        logic [1:0]  src;
        logic [1:0]  dst;
        logic [5:0]  len;
        logic [21:0] tm;
        int          cidx;
        logic [31:0] cmask;
        int          gap;
        logic [31:0] emeta;
        logic [3:0]  eerr;
    } vec_t;

    exp_t        expq[$];
    int          total = 0;
    int          bad = 0;
    int          neg_cnt = 0;
    int          stamp = 0;
    logic [15:0] pkt_m = '0;
    logic [15:0] errc_m = '0;
    bit          open_pkt = 1'b0;
    logic [3:0]  open_err = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Each expected pulse carries the negedge index at which it must appear.
    always @(negedge clk) begin
        exp_t e;
        neg_cnt++;
        if (meta_valid === 1'b1) begin
            if (expq.size() == 0) begin
                chk("spurious_pulse", 64'(meta_valid), 64'(0));
            end else begin
                e = expq.pop_front();
                chk("pulse_cycle", 64'(neg_cnt), 64'(e.neg));
                chk("err", 64'(err), 64'(e.err));
                if (e.chk_meta) chk("meta_out", 64'(meta_out), 64'(e.meta));
                chk("pkt_cnt", 64'(pkt_cnt), 64'(e.pc));
                chk("err_cnt", 64'(err_cnt), 64'(e.ec));
            end
        end else if (expq.size() != 0 && expq[0].neg <= neg_cnt) begin
            e = expq.pop_front();
            chk("missing_pulse", 64'(meta_valid), 64'(1));
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0;
            in_sop   = 1'($urandom);
            in_data  = $urandom;
            @(posedge clk); #1;
        end
    endtask

    task automatic drive_word(input logic [31:0] d, input logic sop);
        in_valid = 1'b1;
        in_sop   = sop;
        in_data  = d;
        stamp    = neg_cnt + 2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_sop   = 1'($urandom);
        in_data  = $urandom;
    endtask

    task automatic push(input logic [31:0] m, input logic [3:0] e, input bit cm);
        exp_t x;
        x.meta = m; x.err = e; x.chk_meta = cm;
        x.pc = pkt_m; x.ec = errc_m; x.neg = stamp;
        expq.push_back(x);
    endtask

    // upto < 0 sends the whole packet; otherwise only the first upto words.
    task automatic send_pkt(input logic [1:0] src, input logic [1:0] dst, input logic [5:0] len,
                            input logic [21:0] tm, input int cidx, input logic [31:0] cmask,
                            input logic [3:0] cbit, input int upto, input int gap,
                            input logic [31:0] emeta);
        logic [31:0] w[$];
        int n;
        w.push_back({5'b0, len, 5'b0, MAC_HI});
        w.push_back(MAC_LO | 32'(dst));
        w.push_back({10'b0, tm});
        w.push_back(32'h0);
        w.push_back({16'b0, MAC_HI});
        w.push_back(MAC_LO | 32'(src));
        for (int i = 0; i <= int'(len); i++) w.push_back(32'hFFFF_FFFF);
        if (cidx >= 0) w[cidx] = w[cidx] ^ cmask;
        n = (upto < 0) ? w.size() : upto;
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                if (gap == 1) idle(1);
                else if (gap == 2) idle(int'($urandom_range(0, 2)));
            end
            drive_word(w[i], i == 0);
            if (i == 0 && open_pkt) begin
                errc_m++;
                push('0, open_err | 4'b0001, 1'b0);
                open_pkt = 1'b0;
            end
        end
        if (n == w.size()) begin
            pkt_m++;
            if (cbit != 0) errc_m++;
            push(emeta, cbit, 1'b1);
            open_pkt = 1'b0;
        end else begin
            open_pkt = 1'b1;
            open_err = (cidx >= 0 && cidx < n) ? cbit : 4'b0;
        end
    endtask

    initial begin
        vec_t tbl[8];
        tbl[0] = '{2'd1, 2'd2, 6'd0,  22'h12345,  -1, 32'h0,         0, 32'h6001_2345, 4'h0};
        tbl[1] = '{2'd0, 2'd3, 6'd63, 22'h3FFFFF, -1, 32'h0,         1, 32'h3FFF_FFFF, 4'h0};
        tbl[2] = '{2'd2, 2'd1, 6'd5,  22'h00ABC,   9, 32'h1,         0, 32'h9140_0ABC, 4'h8};
        tbl[3] = '{2'd3, 2'd2, 6'd1,  22'h1,       1, 32'h0010_0000, 2, 32'hC040_0001, 4'h2};
        tbl[4] = '{2'd1, 2'd1, 6'd2,  22'h1,       2, 32'h8000_0000, 0, 32'h5080_0001, 4'h4};
        tbl[5] = '{2'd2, 2'd3, 6'd4,  22'h2AAAAA,  5, 32'h0000_0100, 2, 32'h312A_AAAA, 4'h2};
        tbl[6] = '{2'd0, 2'd0, 6'd3,  22'h0,       3, 32'h1,         0, 32'h00C0_0000, 4'h4};
        tbl[7] = '{2'd3, 2'd3, 6'd0,  22'h3FFFFF,  0, 32'h0001_0000, 1, 32'hF03F_FFFF, 4'h4};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_meta_valid", 64'(meta_valid), 64'(0));
        chk("rst_meta_out", 64'(meta_out), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_pkt_cnt", 64'(pkt_cnt), 64'(0));
        chk("rst_err_cnt", 64'(err_cnt), 64'(0));
        reset = 1'b1;
        idle(3);

        for (int i = 0; i < 8; i++) begin
            send_pkt(tbl[i].src, tbl[i].dst, tbl[i].len, tbl[i].tm, tbl[i].cidx, tbl[i].cmask,
                     tbl[i].eerr, -1, tbl[i].gap, tbl[i].emeta);
            idle(3);
            if (i == 0) begin
                idle(4);
                chk("hold_meta", 64'(meta_out), 64'(32'h6001_2345));
                chk("hold_err", 64'(err), 64'(0));
                chk("first_pkt_cnt", 64'(pkt_cnt), 64'(1));
            end
        end

        // Sop arriving at word 4, then a clean packet straight after.
        send_pkt(2'd1, 2'd2, 6'd2, 22'h5, -1, 32'h0, 4'h0, 4, 0, 32'h0);
        send_pkt(2'd1, 2'd2, 6'd0, 22'h12345, -1, 32'h0, 4'h0, -1, 0, 32'h6001_2345);
        // Back-to-back complete packets with no idle gap.
        send_pkt(2'd2, 2'd0, 6'd1, 22'h777, -1, 32'h0, 4'h0, -1, 0, 32'h8040_0777);
        send_pkt(2'd3, 2'd1, 6'd0, 22'h8, -1, 32'h0, 4'h0, -1, 0, 32'hD000_0008);
        idle(3);

        for (int k = 0; k < 40; k++) begin
            logic [1:0]  s, d, se, de;
            logic [5:0]  ln;
            logic [21:0] t;
            int          ci, up;
            logic [31:0] cm;
            logic [3:0]  cb;
            s  = 2'($urandom);
            d  = 2'($urandom);
            ln = ($urandom_range(0, 9) == 0) ? 6'd63 : 6'($urandom_range(0, 12));
            t  = 22'($urandom);
            ci = -1; cm = '0; cb = '0; se = s; de = d;
            case ($urandom_range(0, 5))
                1: begin ci = 1; cm = 32'h1 << $urandom_range(2, 31); cb = 4'b0010; de = 2'd0; end
                2: begin ci = 5; cm = 32'h1 << $urandom_range(2, 31); cb = 4'b0010; se = 2'd0; end
                3: begin
                    cb = 4'b0100;
                    case ($urandom_range(0, 3))
                        0: begin
                            ci = 0;
                            cm = 32'h1 << (($urandom_range(0, 1) == 1) ? $urandom_range(27, 31)
                                                                         : $urandom_range(16, 20));
                        end
                        1: begin ci = 2; cm = 32'h1 << $urandom_range(22, 31); end
                        2: begin ci = 3; cm = 32'h1 << $urandom_range(0, 31); end
                        default: begin ci = 4; cm = 32'h1 << $urandom_range(16, 31); end
                    endcase
                end
                4: begin
                    ci = 6 + int'($urandom_range(0, int'(ln)));
                    cm = $urandom;
                    if (cm == 0) cm = 32'h1;
                    cb = 4'b1000;
                end
                default: ;
            endcase
            up = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, int'(ln) + 6)) : -1;
            send_pkt(s, d, ln, t, ci, cm, cb, up, int'($urandom_range(0, 2)), {se, de, ln, t});
            if (up < 0 && $urandom_range(0, 3) == 0) begin
                for (int g = 0; g < 3; g++) drive_word($urandom, 1'b0);
            end
        end
        if (open_pkt) send_pkt(2'd0, 2'd1, 6'd0, 22'h1, -1, 32'h0, 4'h0, -1, 0, 32'h1000_0001);
        idle(5);
        chk("rand_pkt_cnt", 64'(pkt_cnt), 64'(pkt_m));
        chk("rand_err_cnt", 64'(err_cnt), 64'(errc_m));

        // Asynchronous reset in the middle of a payload.
        send_pkt(2'd2, 2'd1, 6'd5, 22'h3, -1, 32'h0, 4'h0, 8, 0, 32'h0);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_meta_valid", 64'(meta_valid), 64'(0));
        chk("mid_rst_meta_out", 64'(meta_out), 64'(0));
        chk("mid_rst_err", 64'(err), 64'(0));
        chk("mid_rst_pkt_cnt", 64'(pkt_cnt), 64'(0));
        chk("mid_rst_err_cnt", 64'(err_cnt), 64'(0));
        expq.delete();
        open_pkt = 1'b0;
        pkt_m = '0;
        errc_m = '0;
        @(posedge clk); @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk); #1;
        for (int g = 0; g < 3; g++) drive_word($urandom, 1'b0);
        idle(2);
        chk("post_rst_pkt_cnt", 64'(pkt_cnt), 64'(0));
        chk("post_rst_err_cnt", 64'(err_cnt), 64'(0));
        send_pkt(2'd1, 2'd2, 6'd0, 22'h12345, -1, 32'h0, 4'h0, -1, 0, 32'h6001_2345);
        idle(4);
        chk("post_rst_clean_cnt", 64'(pkt_cnt), 64'(1));

        idle(6);
        chk("queue_drained", 64'(expq.size()), 64'(0));
        chk("final_pkt_cnt", 64'(pkt_cnt), 64'(pkt_m));
        chk("final_err_cnt", 64'(err_cnt), 64'(errc_m));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/packet_parse.md
Name: packet_parse

Overview:
- Receive-side counterpart of the packet generator: consumes the 32-bit word stream the generator emits and reconstructs the original 32-bit packet metadata word.
- Validates the framing and reports per-packet errors.
- Sits at the switch egress/test sink, feeding metadata to the stats/compare logic.

Parameters:
- PORT_CNT, 4, number of switch ports; MAC lookup covers ports 0..PORT_CNT-1.
- CNT_WIDTH, 16, width of packet/error counters.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  word on in_data valid this cycle
- in_sop  in  1  first word of a packet, qualified by in_valid
- in_data  in  32  packet word
- meta_valid  out  1  one-cycle pulse: meta_out/err valid
- meta_out  out  32  {src_port[31:30], dst_port[29:28], len[27:22], time[21:0]}
- err  out  4  {payload_err, fmt_err, mac_err, trunc_err}
- pkt_cnt  out  CNT_WIDTH  packets completed, error-free or not
- err_cnt  out  CNT_WIDTH  packets completed or aborted with any err bit set

Behaviour:
- Framing (word index counts only in_valid cycles):
  - w0 = {len*32 [31:16], DMAC[47:32]}
  - w1 = DMAC[31:0]
  - w2 = {10'b0, time[21:0]}
  - w3 = 32'b0
  - w4 = {16'b0, SMAC[47:32]}
  - w5 = SMAC[31:0]
  - then len+1 payload words, each 32'hFFFF_FFFF.
- States: IDLE, DMAC_SND, TIME_FST, TIME_SND, SMAC_FST, SMAC_SND, PAYLOAD. Advance only on in_valid; hold otherwise (no backpressure, input always accepted).
- IDLE:
  - in_valid & in_sop: latch len = in_data[26:21] and DMAC hi, clear error accumulators, go DMAC_SND.
  - fmt_err if in_data[31:27] != 0 or in_data[20:16] != 0.
  - in_valid & !in_sop: word dropped, no output, counters unchanged.
- DMAC_SND:
  - Assemble DMAC; match against port_to_mac(p) for p = 0..PORT_CNT-1 (one instance each).
  - Hit: dst_port = p. Miss: mac_err = 1, dst_port = 0.
- TIME_FST: time = in_data[21:0]; fmt_err if in_data[31:22] != 0.
- TIME_SND: fmt_err if word != 0.
- SMAC_FST: fmt_err if in_data[31:16] != 0.
- SMAC_SND:
  - SMAC lookup sets src_port or mac_err, same as DMAC.
  - Load remaining = len; go PAYLOAD.
- PAYLOAD:
  - Each word: payload_err if != all-ones.
  - remaining > 0: decrement.
  - remaining == 0: packet complete, go IDLE.
- Completion:
  - meta_valid pulses the cycle after the last payload word is accepted; meta_out and err are registered and hold until the next pulse.
  - pkt_cnt += 1; err_cnt += 1 if err != 0.
  - Both counters wrap at 2^CNT_WIDTH.
- Early sop: in_valid & in_sop in any non-IDLE state aborts the current packet.
  - Pulse meta_valid next cycle with partial meta and trunc_err = 1; err_cnt += 1, pkt_cnt unchanged.
  - The same word is parsed as w0 of a new packet (state -> DMAC_SND).
- in_sop without in_valid is ignored.
- Back-to-back: a new sop in the cycle right after the final payload word is accepted normally; no idle cycle is required.
- Reset (asynchronous assert, any time including mid-packet):
  - state = IDLE; meta_valid = 0, meta_out = 0, err = 0, pkt_cnt = 0, err_cnt = 0; partial packet discarded.
  - Release is synchronised internally; first parse occurs no earlier than the 2nd clk edge after deassertion.

Test Plan:
- Clean packet src 1, dst 2, len 0, time 22'h12345: 7 words contiguous -> one meta_valid 1 cycle after w6, meta_out = 32'h6001_2345, err = 0, pkt_cnt = 1.
- len 63 packet with in_valid toggling every other cycle: 6 + 64 words -> single pulse after 70th accepted word, len field = 63, err = 0.
- Payload word 3 = 32'hFFFF_FFFE, otherwise clean len 5 -> err = 4'b1000, err_cnt = 1, pkt_cnt = 1.
- w1 altered so DMAC matches no port -> err[1] = 1, dst_port = 0; w2 = 32'h8000_0001 on another packet -> err[2] = 1.
- New sop at w4 of a packet, then a complete clean packet -> first pulse err = 4'b0001 with pkt_cnt unchanged; second pulse err = 0; pkt_cnt = 1, err_cnt = 1.
- reset low during PAYLOAD, released, 3 non-sop words then a clean packet -> no pulse before sop; counters 0 until the clean packet, then pkt_cnt = 1.
